spi_reg_bridge: RTL and testbench

//  Sits directly downstream of the SPI slave byte engine: consumes received bytes (rx_data/rx_tick),

---
 rtl/spi_reg_bridge.sv | 98 +++++++++
 tb/tb_spi_reg_bridge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte stream to 8-bit register bus bridge.
// Burst address increment is enabled by defining SPI_BRIDGE_AUTOINC_EN.
module spi_reg_bridge #(
  parameter int          ADDR_W = 7,
  parameter logic [7:0]  STATUS = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ncs,
  input  logic [7:0]        rx_data,
  input  logic              rx_tick,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD_FETCH, RD} state_t;

`ifdef SPI_BRIDGE_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADV = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ADV = '0;
`endif

  state_t state;
  // Cleared by reset so a frame interrupted by reset is ignored until ncs toggles.
  logic   armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      tx_data   <= STATUS;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bus_we <= 1'b0;
      bus_re <= 1'b0;
      if (ncs) begin
        state   <= IDLE;
        armed   <= 1'b1;
        tx_data <= STATUS;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (armed) state <= CMD;
            tx_data <= STATUS;
          end
          CMD: begin
            tx_data <= STATUS;
            if (rx_tick) begin
              bus_addr <= rx_data[ADDR_W-1:0];
              busy     <= 1'b1;
              if (rx_data[7]) begin
                bus_re <= 1'b1;
                state  <= RD_FETCH;
              end else begin
                state  <= WR;
              end
            end
          end
          WR: begin
            // Address moves on only after the strobe has been seen at the old address.
            if (bus_we) bus_addr <= bus_addr + ADV;
            if (rx_tick) begin
              bus_wdata <= rx_data;
              bus_we    <= 1'b1;
            end
          end
          RD_FETCH: begin
            // bus_rdata is valid the clock after the strobe, so capture once it drops.
            if (!bus_re) begin
              tx_data <= bus_rdata;
              state   <= RD;
            end
          end
          RD: begin
            if (rx_tick) begin
              bus_addr <= bus_addr + ADV;
              bus_re   <= 1'b1;
              state    <= RD_FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - directed table-driven bench for spi_reg_bridge.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       ncs;
  logic [7:0] rx_data;
  logic       rx_tick;
  logic [7:0] tx_data;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       busy;

  int errors = 0;
  int checks = 0;

  spi_reg_bridge #(.ADDR_W(7), .STATUS(8'hA5)) dut (
    .clk(clk), .reset(reset), .ncs(ncs), .rx_data(rx_data), .rx_tick(rx_tick),
    .tx_data(tx_data), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_re(bus_re), .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] regs [128];
  logic [6:0] wlog_a [64];
  logic [7:0] wlog_d [64];
  int         wn = 0;
  int         overlap = 0;

  always @(posedge clk) begin
    if (bus_we) begin
      regs[bus_addr] <= bus_wdata;
      wlog_a[wn]     <= bus_addr;
      wlog_d[wn]     <= bus_wdata;
      wn             <= wn + 1;
    end
    if (bus_re) bus_rdata <= regs[bus_addr];
    if (bus_we && bus_re) overlap <= overlap + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (6) @(negedge clk);
    rx_data = b;
    rx_tick = 1'b1;
    @(negedge clk);
    rx_tick = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] cmd, b1, b2;
    logic [7:0] e1, e2;       // read: tx after cmd / after b1; write: data of each strobe
    logic [6:0] a1, a2;       // write addresses
  } vec_t;

  vec_t vecs [5];
  int   start;

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[7'h7F] = 8'h3C;
    regs[7'h00] = 8'hC3;
    bus_rdata = 8'h00;

`ifdef SPI_BRIDGE_AUTOINC_EN
    vecs[0] = '{8'hFF, 8'h00, 8'h00, 8'h3C, 8'hC3, 7'h00, 7'h00};
    vecs[1] = '{8'h05, 8'h11, 8'h22, 8'h11, 8'h22, 7'h05, 7'h06};
    vecs[2] = '{8'h7F, 8'hAA, 8'h55, 8'hAA, 8'h55, 7'h7F, 7'h00};
    vecs[3] = '{8'h85, 8'h00, 8'h00, 8'h11, 8'h22, 7'h00, 7'h00};
    vecs[4] = '{8'hFF, 8'h00, 8'h00, 8'hAA, 8'h55, 7'h00, 7'h00};
`else
    vecs[0] = '{8'hFF, 8'h00, 8'h00, 8'h3C, 8'h3C, 7'h00, 7'h00};
    vecs[1] = '{8'h05, 8'h11, 8'h22, 8'h11, 8'h22, 7'h05, 7'h05};
    vecs[2] = '{8'h7F, 8'hAA, 8'h55, 8'hAA, 8'h55, 7'h7F, 7'h7F};
    vecs[3] = '{8'h85, 8'h00, 8'h00, 8'h22, 8'h22, 7'h00, 7'h00};
    vecs[4] = '{8'hFF, 8'h00, 8'h00, 8'h55, 8'h55, 7'h00, 7'h00};
`endif

    // Reset with ncs held low: reset values, then no strobes until ncs toggles.
    reset = 1'b1; ncs = 1'b0; rx_data = 8'h00; rx_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_data, 8'hA5);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_re", bus_re, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    start = wn;
    send_byte(8'h01);
    send_byte(8'h99);
    chk("rst_no_write", wn - start, 0);
    chk("rst_no_busy", busy, 0);
    ncs = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      start = wn;
      ncs = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_status", i), tx_data, 8'hA5);
      send_byte(vecs[i].cmd);
      chk($sformatf("v%0d_busy", i), busy, 1);
      if (vecs[i].cmd[7]) begin
        chk($sformatf("v%0d_tx1", i), tx_data, vecs[i].e1);
        send_byte(vecs[i].b1);
        chk($sformatf("v%0d_tx2", i), tx_data, vecs[i].e2);
        send_byte(vecs[i].b2);
      end else begin
        send_byte(vecs[i].b1);
        send_byte(vecs[i].b2);
        chk($sformatf("v%0d_nwr", i), wn - start, 2);
        chk($sformatf("v%0d_a1", i), wlog_a[start], vecs[i].a1);
        chk($sformatf("v%0d_d1", i), wlog_d[start], vecs[i].e1);
        chk($sformatf("v%0d_a2", i), wlog_a[start+1], vecs[i].a2);
        chk($sformatf("v%0d_d2", i), wlog_d[start+1], vecs[i].e2);
      end
      ncs = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      repeat (2) @(negedge clk);
    end

    // ncs raised after a write command, before any data byte.
    start = wn;
    ncs = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h10);
    ncs = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_tx", tx_data, 8'hA5);
    repeat (4) @(negedge clk);
    chk("abort_no_write", wn - start, 0);

    // ncs rises in the same clock as a data byte tick: write dropped.
    ncs = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h10);
    rx_data = 8'h77; rx_tick = 1'b1; ncs = 1'b1;
    @(negedge clk);
    rx_tick = 1'b0;
    chk("race_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("race_no_write", wn - start, 0);
    chk("race_reg", regs[7'h10], 8'h00);

    // Reset mid-frame: rest of frame ignored, next frame works.
    ncs = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h02);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", bus_addr, 0);
    send_byte(8'h33);
    chk("midrst_no_write", wn - start, 0);
    ncs = 1'b1;
    repeat (2) @(negedge clk);
    ncs = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h02);
    send_byte(8'h44);
    chk("midrst_nwr", wn - start, 1);
    chk("midrst_a", wlog_a[start], 7'h02);
    chk("midrst_d", wlog_d[start], 8'h44);
    ncs = 1'b1;
    repeat (3) @(negedge clk);

    chk("strobe_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
